// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of the byte-addressed data RAM.
// Registers the winning command, issues one RAM access, then returns a registered response.
module ram_arbiter #(
   parameter int unsigned DEPTH_BYTES = 1024
) (
   input  logic        Clock,
   input  logic        nReset,
   input  logic [1:0]  req,
   input  logic [1:0]  we,
   input  logic [5:0]  ctrl,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic [1:0]  gnt,
   output logic [1:0]  rvalid,
   output logic [31:0] rdata,
   output logic        err,
   output logic        ram_writeRam,
   output logic [2:0]  ram_ctrl,
   output logic [31:0] ram_address,
   output logic [31:0] ram_wData,
   input  logic [31:0] ram_rData
);

   localparam logic [2:0] CTRL_NONE = 3'b111;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        cmd_we_q, cmd_we_d;
   logic [2:0]  cmd_ctrl_q, cmd_ctrl_d;
   logic [31:0] cmd_addr_q, cmd_addr_d;
   logic [31:0] cmd_wdata_q, cmd_wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        win_c;
   logic [32:0] size_c;
   logic        cmd_err_c;

   // Round-robin pick: on contention the requester that did not win last time goes next.
   always_comb begin
      win_c = req[1];
      if (req == 2'b11) win_c = ~last_q;
      gnt = 2'b00;
      if ((state_q != ISSUE) && (|req)) gnt = win_c ? 2'b10 : 2'b01;
   end

   // Legality of the captured command; 33-bit sum catches wrap-around past 2^32.
   always_comb begin
      case (cmd_ctrl_q[1:0])
         2'b00:   size_c = 33'd1;
         2'b01:   size_c = 33'd2;
         default: size_c = 33'd4;
      endcase
      cmd_err_c = (cmd_ctrl_q == 3'b011) || (cmd_ctrl_q == 3'b110) || (cmd_ctrl_q == 3'b111)
               || (cmd_we_q && cmd_ctrl_q[2])
               || (({1'b0, cmd_addr_q} + size_c) > 33'(DEPTH_BYTES));
   end

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      cmd_we_d     = cmd_we_q;
      cmd_ctrl_d   = cmd_ctrl_q;
      cmd_addr_d   = cmd_addr_q;
      cmd_wdata_d  = cmd_wdata_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      rvalid       = 2'b00;
      ram_writeRam = 1'b0;
      ram_ctrl     = CTRL_NONE;
      ram_address  = 32'd0;
      ram_wData    = 32'd0;

      case (state_q)
         ISSUE: begin
            ram_writeRam = cmd_we_q && !cmd_err_c;
            ram_ctrl     = cmd_err_c ? CTRL_NONE : cmd_ctrl_q;
            ram_address  = cmd_addr_q;
            ram_wData    = cmd_wdata_q;
            err_d        = cmd_err_c;
            rdata_d      = (!cmd_err_c && !cmd_we_q) ? ram_rData : 32'd0;
            state_d      = RESP;
         end
         RESP: begin
            rvalid  = last_q ? 2'b10 : 2'b01;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A grant in IDLE or RESP captures the winner's payload and starts the next access.
      if (|gnt) begin
         cmd_we_d    = win_c ? we[1] : we[0];
         cmd_ctrl_d  = win_c ? ctrl[5:3] : ctrl[2:0];
         cmd_addr_d  = win_c ? addr[63:32] : addr[31:0];
         cmd_wdata_d = win_c ? wdata[63:32] : wdata[31:0];
         last_d      = win_c;
         state_d     = ISSUE;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         cmd_we_q    <= 1'b0;
         cmd_ctrl_q  <= CTRL_NONE;
         cmd_addr_q  <= 32'd0;
         cmd_wdata_q <= 32'd0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cmd_we_q    <= cmd_we_d;
         cmd_ctrl_q  <= cmd_ctrl_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign rdata = rdata_q;
   assign err   = err_q;

endmodule
